// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core datapath.
package mips_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned SP_IDX_DEF  = 29;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_07FC;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-result counter for one scoreboard entry.
module sb_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         nonzero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         inc_ok;
    logic         dec_ok;

    assign full    = (cnt_q == '1);
    assign nonzero = (cnt_q != '0);
    assign cnt     = cnt_q;
    assign inc_ok  = inc && !full;
    assign dec_ok  = dec && nonzero;

    // Next count: clear wins; a simultaneous accepted inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-back bypass, hardwired r0 and per-register scoreboard.
module regfile_sb
    import mips_pkg::*;
#(
    parameter int unsigned       DATA_W  = DATA_W_DEF,
    parameter int unsigned       ADDR_W  = ADDR_W_DEF,
    parameter int unsigned       NUM_RD  = 2,
    parameter int unsigned       PEND_W  = 2,
    parameter int unsigned       SP_IDX  = SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_full,
    input  logic                     flush,
    output logic                     ovf_err
);

    localparam int unsigned       NREG     = 2**ADDR_W;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [PEND_W-1:0] pend_cnt  [NREG];
    logic              pend_full [NREG];
    logic              pend_nz   [NREG];
    logic              ovf_q;
    logic              ovf_d;

    // Register storage; r0 is never written so it stays constant zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // One pending counter per architectural register; r0 is never pending.
    for (genvar r = 0; r < NREG; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign pend_cnt[r]  = '0;
            assign pend_full[r] = 1'b0;
            assign pend_nz[r]   = 1'b0;
        end else begin : g_cnt
            sb_counter #(
                .W (PEND_W)
            ) u_cnt (
                .clk     (clk),
                .reset   (reset),
                .inc     (rsv_en && !flush && (rsv_addr == ADDR_W'(r))),
                .dec     (wr_en && (wr_addr == ADDR_W'(r))),
                .clr     (flush),
                .cnt     (pend_cnt[r]),
                .full    (pend_full[r]),
                .nonzero (pend_nz[r])
            );
        end
    end

    assign rsv_full = (rsv_addr != '0) && pend_full[rsv_addr];

    // Overflow flag: a dropped reservation latches it until reset.
    always_comb begin
        ovf_d = ovf_q;
        if (rsv_en && rsv_full && !flush) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_err = ovf_q;

    // Read ports: r0, then bypass, then storage; the arriving result is not a stall.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              byp;

        assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
        assign byp = wr_en && (wr_addr == ra);
        assign rd_data[i*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                             byp        ? wr_data : regs_q[ra];
        assign rd_busy[i] = (ra != '0) && pend_nz[ra] &&
                            !(byp && (pend_cnt[ra] == PEND_ONE));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench for regfile_sb against an array-based model.
module tb_regfile_sb;
    import mips_pkg::*;

    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    reg_addr_t   wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    reg_addr_t   rsv_addr;
    logic        rsv_full;
    logic        flush;
    logic        ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_reg  [32];
    int          m_pend [32];
    bit          m_ovf;
    bit          m_valid = 1'b0;

    regfile_sb #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_RD  (2),
        .PEND_W  (2),
        .SP_IDX  (29),
        .SP_INIT (32'h0000_07FC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_full (rsv_full),
        .flush    (flush),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_reg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        int byp;
        byp = (wr_en && wr_addr == a) ? 1 : 0;
        return {31'h0, (a != 0) && (m_pend[a] > byp)};
    endfunction

    // Drive one cycle, check combinational outputs against the model, then advance it.
    task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit re, input logic [4:0] rsa, input bit fl,
                        input logic [4:0] a0, input logic [4:0] a1);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = rsa; flush = fl; rd_addr = {a1, a0};
        @(negedge clk);
        if (m_valid) begin
            check("rd_data0", rd_data[31:0], exp_rd(a0));
            check("rd_data1", rd_data[63:32], exp_rd(a1));
            check("rd_busy0", {31'h0, rd_busy[0]}, exp_busy(a0));
            check("rd_busy1", {31'h0, rd_busy[1]}, exp_busy(a1));
            check("rsv_full", {31'h0, rsv_full}, {31'h0, (rsa != 0) && (m_pend[rsa] == PMAX)});
            check("ovf_err", {31'h0, ovf_err}, {31'h0, m_ovf});
        end
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r]  = (r == 29) ? 32'h0000_07FC : 32'h0;
                m_pend[r] = 0;
            end
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (we && wa != 0) m_reg[wa] = wd;
            if (fl) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 0;
            end else begin
                int old_r, old_w;
                old_r = m_pend[rsa];
                old_w = m_pend[wa];
                if (re && rsa != 0) begin
                    if (old_r < PMAX) m_pend[rsa] = m_pend[rsa] + 1;
                    else m_ovf = 1'b1;
                end
                if (we && wa != 0 && old_w > 0) m_pend[wa] = m_pend[wa] - 1;
            end
        end
        #1;
    endtask

    // Idle cycle comparing port 0 against fixed expected values.
    task automatic probe(input string tag, input logic [4:0] a, input logic [31:0] d,
                         input bit busy, input bit ovf);
        reset = 0; wr_en = 0; rsv_en = 0; flush = 0; rd_addr = {5'd0, a};
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
        @(negedge clk);
        check({tag, "_data"}, rd_data[31:0], d);
        check({tag, "_busy"}, {31'h0, rd_busy[0]}, {31'h0, busy});
        check({tag, "_ovf"}, {31'h0, ovf_err}, {31'h0, ovf});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a += 2)
            step(0, 0, 0, 0, 0, 0, 0, 5'(a), 5'(a + 1));
        probe("sp_init", 29, 32'h0000_07FC, 0, 0);
        probe("r1_init", 1, 32'h0, 0, 0);

        // Write with bypass, and write to r0
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        probe("r5", 5, 32'hDEADBEEF, 0, 0);
        step(0, 1, 0, 32'h1234, 0, 0, 0, 0, 5);
        probe("r0", 0, 32'h0, 0, 0);

        // Two outstanding results on r8
        step(0, 0, 0, 0, 1, 8, 0, 8, 0);
        step(0, 0, 0, 0, 1, 8, 0, 8, 0);
        step(0, 1, 8, 32'h11, 0, 0, 0, 8, 8);
        probe("r8_one_left", 8, 32'h11, 1, 0);
        step(0, 1, 8, 32'h22, 0, 0, 0, 8, 8);
        probe("r8_done", 8, 32'h22, 0, 0);

        // Saturate r3 and overflow
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 3, 0, 3, 0);
        probe("r3_ovf", 3, 32'h0, 1, 1);
        step(0, 0, 0, 0, 0, 3, 0, 3, 0);

        // Reserve and write r9 together
        step(0, 0, 0, 0, 1, 9, 0, 9, 0);
        step(0, 1, 9, 32'h99, 1, 9, 0, 9, 9);
        probe("r9", 9, 32'h99, 1, 1);

        // Flush with concurrent write and reservation
        step(0, 0, 0, 0, 1, 4, 0, 4, 6);
        step(0, 0, 0, 0, 1, 6, 0, 4, 6);
        step(0, 1, 6, 32'h77, 1, 7, 1, 6, 7);
        probe("r6_flush", 6, 32'h77, 0, 1);
        probe("r7_flush", 7, 32'h0, 0, 1);
        probe("r4_flush", 4, 32'h0, 0, 1);

        // Reset clears the sticky flag
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        probe("ovf_clr", 29, 32'h0000_07FC, 0, 0);

        // Random traffic, concentrated on a few registers to create hazards
        for (int n = 0; n < 3000; n++) begin
            bit          rst, we, re, fl;
            logic [4:0]  wa, rsa, a0, a1;
            logic [31:0] wd;
            rst = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 2) == 0);
            re  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            wa  = 5'($urandom_range(0, 7));
            rsa = 5'($urandom_range(0, 7));
            a0  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            wd  = $urandom;
            if (re && we && rsa == wa && (m_pend[rsa] == 0 || m_pend[rsa] == PMAX)) re = 0;
            if (re && fl && m_pend[rsa] == PMAX) re = 0;
            step(rst, we, wa, wd, re, rsa, fl, a0, a1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
